// File: rtl/fifo_audio_player_pkg.sv
// Shared types and helpers for the FIFO-fed PWM audio player.
// The volume helper works on offset-binary PCM bytes.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    READ      = 2'd2,
    CAPTURE   = 2'd3
  } player_state_t;

  localparam logic [7:0] MIDSCALE = 8'h80;

  // Removes the offset, shifts arithmetically, then restores the offset.
  function automatic logic [7:0] apply_volume(input logic [7:0] d, input logic [2:0] v);
    logic signed [7:0] s_s;
    logic signed [7:0] s_att_s;
    s_s     = {~d[7], d[6:0]};
    s_att_s = s_s >>> v;
    return {~s_att_s[7], s_att_s[6:0]};
  endfunction

endpackage

// File: rtl/fifo_audio_player_if.sv
// Read-side handshake between the audio byte FIFO and the player.
// The player is the master: it owns rd_en and consumes empty/dout.
interface fifo_audio_player_if;
  logic       fifo_empty_in;
  logic [7:0] fifo_dout_in;
  logic       fifo_rd_en_out;

  modport master (
    input  fifo_empty_in,
    input  fifo_dout_in,
    output fifo_rd_en_out
  );

  modport slave (
    output fifo_empty_in,
    output fifo_dout_in,
    input  fifo_rd_en_out
  );
endinterface

// File: rtl/fifo_audio_player_pwm_gen.sv
// Free-running PWM generator; the duty value is only taken at the period
// boundary so a period never mixes two samples.
module pwm_gen
  import audio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] duty_in,
  output logic [7:0] sample_out,
  output logic       sample_valid_out,
  output logic       audio_pwm_out
);

  localparam int CMP_W = (PWM_BITS > 8) ? PWM_BITS : 8;

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [7:0]          sample_r;
  logic                valid_r;
  logic                pwm_r;
  logic                wrap_s;

  assign wrap_s = (pwm_cnt_r == {PWM_BITS{1'b1}});

  // Counter, wrap-aligned duty load and registered compare output.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
      sample_r  <= MIDSCALE;
      valid_r   <= 1'b0;
      pwm_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      pwm_r     <= (CMP_W'(pwm_cnt_r) < CMP_W'(sample_r));
      if (wrap_s) begin
        sample_r <= duty_in;
        valid_r  <= 1'b1;
      end else begin
        valid_r  <= 1'b0;
      end
    end
  end

  assign sample_out       = sample_r;
  assign sample_valid_out = valid_r;
  assign audio_pwm_out    = pwm_r;

endmodule

// File: rtl/fifo_audio_player.sv
// Drains PCM bytes from the audio FIFO once per sample tick, applies volume
// and feeds the PWM generator; counts ticks that found the FIFO empty.
module fifo_audio_player
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 520,
  parameter int PWM_BITS   = 8,
  parameter int UNDER_W    = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  play_en_in,
  input  logic [2:0]            volume_in,
  fifo_audio_player_if.master   fifo_bus,
  output logic [7:0]            sample_out,
  output logic                  sample_valid_out,
  output logic                  audio_pwm_out,
  output logic [UNDER_W-1:0]    underrun_count_out
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);

  player_state_t       state_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic                tick_s;
  logic                rd_en_r;
  logic [UNDER_W-1:0]  underrun_r;
  logic [7:0]          pending_r;
  logic [7:0]          pending_nxt_s;

  assign tick_s = (tick_cnt_r == TICK_W'(SAMPLE_DIV - 1));

  // Sample-rate divider, free-running even while paused.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Player FSM: one FIFO read per tick, underrun accounting on empty ticks.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r    <= IDLE;
      rd_en_r    <= 1'b0;
      underrun_r <= {UNDER_W{1'b0}};
    end else begin
      rd_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (play_en_in) begin
            state_r <= WAIT_TICK;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_TICK: begin
          if (!play_en_in) begin
            state_r <= IDLE;
          end else if (tick_s && !fifo_bus.fifo_empty_in) begin
            state_r <= READ;
            rd_en_r <= 1'b1;
          end else if (tick_s) begin
            // Empty at the tick: the previous sample simply repeats.
            if (underrun_r != {UNDER_W{1'b1}}) begin
              underrun_r <= underrun_r + UNDER_W'(1);
            end else begin
              underrun_r <= underrun_r;
            end
          end else begin
            state_r <= WAIT_TICK;
          end
        end
        READ: begin
          state_r <= CAPTURE;
        end
        CAPTURE: begin
          if (play_en_in) begin
            state_r <= WAIT_TICK;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next pending sample; fed straight to the PWM so a same-cycle wrap sees it.
  always_comb begin
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE:    pending_nxt_s = MIDSCALE;
      CAPTURE: pending_nxt_s = apply_volume(fifo_bus.fifo_dout_in, volume_in);
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Pending sample register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pending_r <= MIDSCALE;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .duty_in          (pending_nxt_s),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .audio_pwm_out    (audio_pwm_out)
  );

  assign fifo_bus.fifo_rd_en_out = rd_en_r;
  assign underrun_count_out      = underrun_r;

endmodule

// File: tb/tb_fifo_audio_player.sv
// Directed bench for fifo_audio_player with a small byte-FIFO model and a
// second narrow-counter instance for underrun saturation.
module tb_fifo_audio_player;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        play_en = 1'b1;
  logic [2:0]  volume = 3'd0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        audio_pwm;
  logic [15:0] underrun;

  logic [7:0]  sample2;
  logic        valid2;
  logic        pwm2;
  logic [2:0]  underrun2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int bad_rd = 0;
  int rd_cyc [0:31];

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_audio_player_if fifo_bus ();
  fifo_audio_player_if fifo_bus2 ();

  fifo_audio_player dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .play_en_in         (play_en),
    .volume_in          (volume),
    .fifo_bus           (fifo_bus),
    .sample_out         (sample_out),
    .sample_valid_out   (sample_valid),
    .audio_pwm_out      (audio_pwm),
    .underrun_count_out (underrun)
  );

  fifo_audio_player #(.UNDER_W(3)) dut2 (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .play_en_in         (1'b1),
    .volume_in          (3'd0),
    .fifo_bus           (fifo_bus2),
    .sample_out         (sample2),
    .sample_valid_out   (valid2),
    .audio_pwm_out      (pwm2),
    .underrun_count_out (underrun2)
  );

  always #5 clk = ~clk;

  assign fifo_bus.fifo_empty_in  = (wr_ptr == rd_ptr);
  assign fifo_bus2.fifo_empty_in = 1'b1;
  assign fifo_bus2.fifo_dout_in  = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_bus.fifo_rd_en_out) begin
      if (wr_ptr == rd_ptr) begin
        bad_rd <= bad_rd + 1;
      end else begin
        fifo_bus.fifo_dout_in <= mem[rd_ptr % 16];
        rd_ptr <= rd_ptr + 1;
      end
      if (rd_cnt < 32) rd_cyc[rd_cnt] <= cyc;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic do_reset(output int base);
    rst_n = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic wait_rd(input int budget, output bit seen, output int t);
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (fifo_bus.fifo_rd_en_out) begin
        seen = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // One read, wait for the sample to land at a PWM wrap, optionally measure duty.
  task automatic play_one(input string tag, input logic [7:0] exp, input bit measure, output int t);
    bit seen;
    int high;
    wait_rd(600, seen, t);
    check({tag, "_rd"}, 32'(seen), 32'd1);
    step();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      seen = sample_valid;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_sample"}, 32'(sample_out), 32'(exp));
    if (measure) begin
      high = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        high += int'(audio_pwm);
      end
      check({tag, "_pwm_high"}, 32'(high), 32'(exp));
    end
  endtask

  initial begin
    int base;
    int t0, t1, t2, tr;
    int exp_rd;
    bit seen;

    // Reset with play enabled and bytes waiting: nothing may be read.
    push(8'h00);
    push(8'h40);
    push(8'hFF);
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_rd_en", 32'(fifo_bus.fifo_rd_en_out), 32'd0);
    end
    check("rst_sample", 32'(sample_out), 32'h80);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_pwm", 32'(audio_pwm), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    rst_n = 1'b1;
    base = cyc;

    // Three bytes at full volume, with PWM duty measured for each.
    play_one("s00", 8'h00, 1'b1, t0);
    check("first_rd_time", 32'(t0 - base), 32'd520);
    play_one("s40", 8'h40, 1'b1, t1);
    play_one("sFF", 8'hFF, 1'b1, t2);
    check("rd_gap1", 32'(t1 - t0), 32'd520);
    check("rd_gap2", 32'(t2 - t1), 32'd520);
    check("rd_gap_log", 32'(rd_cyc[2] - rd_cyc[1]), 32'd520);
    exp_rd = 3;

    // FIFO now empty: five ticks of underrun, last sample held.
    wait_until(t2 + 2605);
    check("ur_count", 32'(underrun), 32'd5);
    check("ur_sample_held", 32'(sample_out), 32'hFF);
    check("ur_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // Volume arithmetic.
    push(8'hFF);
    push(8'h00);
    push(8'h80);
    push(8'h00);
    do_reset(base);
    volume = 3'd1;
    play_one("vol_FF_1", 8'hBF, 1'b0, tr);
    volume = 3'd7;
    play_one("vol_00_7", 8'h7F, 1'b0, tr);
    volume = 3'd3;
    play_one("vol_80_3", 8'h80, 1'b0, tr);
    volume = 3'd1;
    play_one("vol_00_1", 8'h40, 1'b0, tr);
    exp_rd += 4;
    check("vol_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // Pause while rd_en is high: byte still captured, then idle at mid-scale.
    volume = 3'd0;
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    do_reset(base);
    wait_rd(600, seen, tr);
    check("pause_rd", 32'(seen), 32'd1);
    play_en = 1'b0;
    step();
    step();
    check("pause_captured", 32'(dut.pending_r), 32'h3C);
    check("pause_state", 32'(dut.state_r), 32'(IDLE));
    step();
    check("pause_pending_mid", 32'(dut.pending_r), 32'h80);
    repeat (300) step();
    check("pause_sample_mid", 32'(sample_out), 32'h80);
    repeat (600) step();
    exp_rd += 1;
    check("pause_no_reads", 32'(rd_cnt), 32'(exp_rd));

    // Saturation on the narrow instance; main DUT drains 0x11, 0x22 meanwhile.
    play_en = 1'b1;
    do_reset(base);
    wait_until(base + 3645);
    check("sat_at_max", 32'(underrun2), 32'd7);
    wait_until(base + 4685);
    check("sat_held", 32'(underrun2), 32'd7);
    exp_rd += 2;
    check("sat_main_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // Reset while in CAPTURE discards the byte and does not re-read.
    push(8'h5A);
    wait_rd(600, seen, tr);
    check("capt_rd", 32'(seen), 32'd1);
    exp_rd += 1;
    step();
    check("capt_state", 32'(dut.state_r), 32'(CAPTURE));
    rst_n = 1'b0;
    step();
    check("capt_rst_pending", 32'(dut.pending_r), 32'h80);
    check("capt_rst_state", 32'(dut.state_r), 32'(IDLE));
    check("capt_rst_sample", 32'(sample_out), 32'h80);
    check("capt_rst_rd_en", 32'(fifo_bus.fifo_rd_en_out), 32'd0);
    repeat (3) step();
    play_en = 1'b0;
    rst_n = 1'b1;
    repeat (600) step();
    check("capt_no_reread", 32'(rd_cnt), 32'(exp_rd));
    check("rd_while_empty", 32'(bad_rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
